// File: rtl/bus_arbiter_rr.sv
// Round-robin request/grant arbiter driving a registered broadcast bus for M devices.
// Optional tenure limit (forced rotation after MAX_HOLD cycles) compiled in with BUS_HOLD_LIMIT_EN.
module bus_arbiter_rr #(
  parameter int N        = 8,
  parameter int M        = 4,
  parameter int MAX_HOLD = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [M-1:0]           req,
  input  logic [M*N-1:0]         data_in,
  output logic [M-1:0]           grant,
  output logic [N-1:0]           bus,
  output logic                   bus_valid,
  output logic [$clog2(M)-1:0]   bus_src
);

  localparam int SW = $clog2(M);

  localparam logic IDLE  = 1'b0;
  localparam logic OWNED = 1'b1;

  if (M < 2 || MAX_HOLD < 1) begin : g_bad_cfg
    $error("bus_arbiter_rr: needs M >= 2 and MAX_HOLD >= 1");
  end

  // First requester found scanning upward from last+1, wrapping at M.
  function automatic logic [SW-1:0] rr_pick(input logic [M-1:0] r, input logic [SW-1:0] last);
    logic [SW-1:0] pick;
    logic          found;
    int            idx;
    pick  = '0;
    found = 1'b0;
    for (int k = 1; k <= M; k++) begin
      idx = (int'(last) + k) % M;
      if (!found && r[idx]) begin
        pick  = SW'(idx);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  logic          state_q, state_d;
  logic [M-1:0]  grant_q, grant_d;
  logic [SW-1:0] owner_q, owner_d;
  logic [SW-1:0] last_owner_q, last_owner_d;
  logic [N-1:0]  bus_q, bus_d;
  logic          bus_valid_q, bus_valid_d;
  logic [SW-1:0] bus_src_q, bus_src_d;
  logic [SW-1:0] winner;

`ifdef BUS_HOLD_LIMIT_EN
  localparam int HW = $clog2(MAX_HOLD + 1);
  logic [HW-1:0] hold_cnt_q, hold_cnt_d;
`endif

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
`ifdef BUS_HOLD_LIMIT_EN
    hold_cnt_d   = hold_cnt_q;
`endif
    // While owned, last_owner equals owner, so the scan reaches the owner only if nobody else asks.
    winner = rr_pick(req, last_owner_q);

    if (state_q == IDLE || !req[owner_q]) begin
      if (|req) begin
        state_d      = OWNED;
        owner_d      = winner;
        last_owner_d = winner;
        grant_d      = M'(1) << winner;
`ifdef BUS_HOLD_LIMIT_EN
        hold_cnt_d   = HW'(1);
`endif
      end else begin
        state_d = IDLE;
        grant_d = '0;
`ifdef BUS_HOLD_LIMIT_EN
        hold_cnt_d = '0;
`endif
      end
    end else begin
`ifdef BUS_HOLD_LIMIT_EN
      if (hold_cnt_q == HW'(MAX_HOLD)) begin
        owner_d      = winner;
        last_owner_d = winner;
        grant_d      = M'(1) << winner;
        hold_cnt_d   = HW'(1);
      end else begin
        hold_cnt_d = hold_cnt_q + HW'(1);
      end
`endif
    end
  end

  always_comb begin
    bus_d       = bus_q;
    bus_valid_d = 1'b0;
    bus_src_d   = bus_src_q;
    if (state_q == OWNED) begin
      bus_d       = data_in[int'(owner_q)*N +: N];
      bus_valid_d = 1'b1;
      bus_src_d   = owner_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      owner_q      <= '0;
      last_owner_q <= SW'(M - 1);
      bus_q        <= '0;
      bus_valid_q  <= 1'b0;
      bus_src_q    <= '0;
`ifdef BUS_HOLD_LIMIT_EN
      hold_cnt_q   <= '0;
`endif
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      bus_q        <= bus_d;
      bus_valid_q  <= bus_valid_d;
      bus_src_q    <= bus_src_d;
`ifdef BUS_HOLD_LIMIT_EN
      hold_cnt_q   <= hold_cnt_d;
`endif
    end
  end

  assign grant     = grant_q;
  assign bus       = bus_q;
  assign bus_valid = bus_valid_q;
  assign bus_src   = bus_src_q;

endmodule
